// File: rtl/icache_dm.sv
// icache_dm: direct-mapped blocking instruction cache, one-cycle hits, single-beat line refill
module icache_dm #(
  parameter int ICLN     = 4,
  parameter int ICLLEN   = 128,
  parameter int MBLEN    = 128,
  parameter int PHY_LEN  = 20,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  input  logic [PHY_LEN-1:0]  req_addr_i,
  output logic                req_ready_o,
  output logic                rsp_valid_o,
  output logic [INST_LEN-1:0] rsp_inst_o,
  input  logic                flush_i,
  output logic                mem_req_o,
  output logic [PHY_LEN-1:0]  mem_addr_o,
  input  logic                mem_rsp_valid_i,
  input  logic [MBLEN-1:0]    mem_rsp_data_i
);
  localparam int IDX_W = $clog2(ICLN);
  localparam int OFF_W = $clog2(ICLLEN / 8);
  localparam int TAG_W = PHY_LEN - IDX_W - OFF_W;
  localparam int K_W   = OFF_W - 2;
  typedef enum logic {IDLE, MISS} state_t;
  state_t            state;
  logic [ICLN-1:0]   valid, valid_nxt;
  logic [TAG_W-1:0]  tag_q [ICLN];
  logic [ICLLEN-1:0] data_q [ICLN];
  logic [IDX_W-1:0]  idx, m_idx;
  logic [TAG_W-1:0]  tag, m_tag;
  logic [K_W-1:0]    k, miss_k;
  logic              accept, hit, refill;
  logic              unused_ok;
  // The refill target is taken from the held mem_addr_o, so the miss only needs to remember the word select.
  always_comb begin
    idx       = req_addr_i[OFF_W +: IDX_W];
    tag       = req_addr_i[PHY_LEN-1 -: TAG_W];
    k         = req_addr_i[2 +: K_W];
    m_idx     = mem_addr_o[OFF_W +: IDX_W];
    m_tag     = mem_addr_o[PHY_LEN-1 -: TAG_W];
    accept    = req_valid_i & req_ready_o & (state == IDLE);
    hit       = valid[idx] & (tag_q[idx] == tag) & ~flush_i;
    refill    = (state == MISS) & mem_rsp_valid_i;
    valid_nxt = (flush_i ? '0 : valid) | (refill ? ICLN'(1) << m_idx : '0);
    unused_ok = ^req_addr_i[1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_inst_o  <= '0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      miss_k      <= '0;
    end else begin
      valid       <= valid_nxt;
      rsp_valid_o <= 1'b0;
      if (accept && hit) begin
        rsp_valid_o <= 1'b1;
        rsp_inst_o  <= data_q[idx][k*INST_LEN +: INST_LEN];
      end else if (accept) begin
        state       <= MISS;
        req_ready_o <= 1'b0;
        mem_req_o   <= 1'b1;
        mem_addr_o  <= {req_addr_i[PHY_LEN-1:OFF_W], OFF_W'(0)};
        miss_k      <= k;
      end else if (refill) begin
        state       <= IDLE;
        req_ready_o <= 1'b1;
        mem_req_o   <= 1'b0;
        rsp_valid_o <= 1'b1;
        rsp_inst_o  <= mem_rsp_data_i[miss_k*INST_LEN +: INST_LEN];
      end
    end
  end
  // Tag and data arrays carry no reset; only the valid bits decide whether they are trusted.
  always_ff @(posedge clk) begin
    if (refill) begin
      tag_q[m_idx]  <= m_tag;
      data_q[m_idx] <= mem_rsp_data_i;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed vector table, corner-case sequences and randomized fetches against a line-level cache model
module tb_icache_dm;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         req_valid_i = 1'b0, flush_i = 1'b0, mem_rsp_valid_i = 1'b0;
  logic [19:0]  req_addr_i = '0;
  logic [127:0] mem_rsp_data_i = '0;
  logic         req_ready_o, rsp_valid_o, mem_req_o;
  logic [31:0]  rsp_inst_o;
  logic [19:0]  mem_addr_o;
  int           tests = 0, fails = 0;
  string        ctx;
  logic [3:0]   mv;
  logic [13:0]  mt [4];
  typedef struct {
    logic [19:0] a;
    logic        fl;
    logic        em;
    logic [31:0] ei;
    int          dly;
  } vec_t;
  vec_t tv [9];
  always #5 clk = ~clk;
  icache_dm dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_inst_o(rsp_inst_o), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i)
  );
  // Backing memory: line 0x01000 holds word k = k*0x11111111, every other line a hash of its address.
  function automatic logic [31:0] mem_word(input logic [19:0] la, input int k);
    if (la == 20'h01000) return 32'h11111111 * k;
    return {la[19:4], 16'h5a5a} ^ (32'h9E3779B9 * (k + 1));
  endfunction
  function automatic logic [127:0] line_data(input logic [19:0] la);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[k*32 +: 32] = mem_word(la, k);
    return d;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s: got %h expected %h", ctx, n, act, exp);
    end
  endtask
  task automatic fetch(input logic [19:0] a, input logic fl, input logic em,
                       input logic [31:0] ei, input int dly, input logic rnd);
    logic [19:0] la;
    logic        fa;
    la = a & ~20'hF;
    fa = fl;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    flush_i     = fl;
    @(negedge clk);
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    chk("mem_req", {31'b0, mem_req_o}, {31'b0, em});
    if (em) begin
      chk("mem_addr", {12'b0, mem_addr_o}, {12'b0, la});
      chk("ready_miss", {31'b0, req_ready_o}, 32'd0);
      chk("early_rsp", {31'b0, rsp_valid_o}, 32'd0);
      for (int i = 0; i <= dly; i++) begin
        if (rnd) begin
          req_valid_i = 1'($urandom);
          req_addr_i  = 20'($urandom);
          flush_i     = ($urandom_range(0, 3) == 0);
          fa          = fa | flush_i;
        end
        mem_rsp_valid_i = (i == dly);
        mem_rsp_data_i  = (i == dly) ? line_data(la) : {4{$urandom}};
        @(negedge clk);
        if (i < dly) begin
          chk("mem_req_hold", {31'b0, mem_req_o}, 32'd1);
          chk("mem_addr_hold", {12'b0, mem_addr_o}, {12'b0, la});
          chk("wait_rsp", {31'b0, rsp_valid_o}, 32'd0);
        end
      end
      req_valid_i     = 1'b0;
      flush_i         = 1'b0;
      mem_rsp_valid_i = 1'b0;
      chk("mem_req_done", {31'b0, mem_req_o}, 32'd0);
      chk("ready_done", {31'b0, req_ready_o}, 32'd1);
    end
    chk("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("rsp_inst", rsp_inst_o, ei);
    if (fa) mv = '0;
    if (em) begin
      mv[a[5:4]] = 1'b1;
      mt[a[5:4]] = a[19:6];
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [19:0] a;
    logic        fl, em;
    tv[0] = '{20'h01004, 1'b0, 1'b1, 32'h11111111, 0};
    tv[1] = '{20'h01000, 1'b0, 1'b0, 32'h00000000, 0};
    tv[2] = '{20'h01008, 1'b0, 1'b0, 32'h22222222, 0};
    tv[3] = '{20'h0100C, 1'b0, 1'b0, 32'h33333333, 0};
    tv[4] = '{20'h01010, 1'b0, 1'b1, mem_word(20'h01010, 0), 2};
    tv[5] = '{20'h01040, 1'b0, 1'b1, mem_word(20'h01040, 0), 1};
    tv[6] = '{20'h01000, 1'b0, 1'b1, 32'h00000000, 3};
    tv[7] = '{20'h01000, 1'b1, 1'b1, 32'h00000000, 0};
    tv[8] = '{20'h01010, 1'b0, 1'b1, mem_word(20'h01010, 0), 1};
    repeat (3) @(negedge clk);
    ctx = "reset";
    chk("ready", {31'b0, req_ready_o}, 32'd1);
    chk("rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rsp_inst", rsp_inst_o, 32'd0);
    chk("mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("mem_addr", {12'b0, mem_addr_o}, 32'd0);
    rst_n = 1'b1;
    mv    = '0;
    for (int i = 0; i < 9; i++) begin
      ctx = $sformatf("vec%0d", i);
      fetch(tv[i].a, tv[i].fl, tv[i].em, tv[i].ei, tv[i].dly, 1'b0);
    end
    ctx = "b2b_hits";
    req_valid_i = 1'b1;
    req_addr_i  = 20'h01000;
    @(negedge clk);
    chk("rsp0_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("rsp0_inst", rsp_inst_o, 32'h00000000);
    req_addr_i = 20'h01008;
    @(negedge clk);
    chk("rsp1_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("rsp1_inst", rsp_inst_o, 32'h22222222);
    req_addr_i = 20'h0100C;
    @(negedge clk);
    chk("rsp2_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("rsp2_inst", rsp_inst_o, 32'h33333333);
    chk("mem_req", {31'b0, mem_req_o}, 32'd0);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("pulse_end", {31'b0, rsp_valid_o}, 32'd0);
    chk("inst_hold", rsp_inst_o, 32'h33333333);
    ctx = "spurious";
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = {4{32'hDEADBEEF}};
    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    chk("rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("ready", {31'b0, req_ready_o}, 32'd1);
    fetch(20'h01004, 1'b0, 1'b0, 32'h11111111, 0, 1'b0);
    fetch(20'h01020, 1'b0, 1'b1, mem_word(20'h01020, 0), 1, 1'b0);
    ctx = "rst_miss";
    req_valid_i = 1'b1;
    req_addr_i  = 20'h01030;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("mem_req", {31'b0, mem_req_o}, 32'd1);
    rst_n           = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = line_data(20'h01030);
    @(negedge clk);
    rst_n           = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mv              = '0;
    chk("mem_req_drop", {31'b0, mem_req_o}, 32'd0);
    chk("ready", {31'b0, req_ready_o}, 32'd1);
    chk("no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    @(negedge clk);
    chk("still_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    fetch(20'h01000, 1'b0, 1'b1, 32'h00000000, 0, 1'b0);
    fetch(20'h01030, 1'b0, 1'b1, mem_word(20'h01030, 0), 0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      ctx = $sformatf("rand%0d", n);
      a  = {12'h010, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom)};
      fl = ($urandom_range(0, 9) == 0);
      em = fl | !(mv[a[5:4]] && mt[a[5:4]] == a[19:6]);
      fetch(a, fl, em, mem_word(a & ~20'hF, int'(a[3:2])), $urandom_range(0, 3), 1'b1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
